eq_miter_mon: RTL and testbench

- Run-time miter for the golden/revised equivalence samples.
- Consumes the registered outputs of a golden design and its revised counterpart, driven by identical stimulus.
- Aligns the two streams, suppresses start-up cycles, and compares them cycle by cycle.
- Reports mismatch pulses, a sticky fail flag, statistics, and the first failing cycle and bit mask. It is the checking end that reads what the sample pairs produce.

---
 rtl/eq_miter_pkg.sv | 28 ++
 rtl/eq_miter_mon_dly.sv | 34 +++
 rtl/eq_miter_mon.sv | 142 ++++++++++++++
 tb/tb_eq_miter_mon.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_miter_pkg.sv
// Shared types and helpers for the eq_miter run-time equivalence monitor.
// Counter widths handled by sat_inc are limited to 32 bits.
package eq_miter_pkg;

  // Monitor FSM states; encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_FAIL    = 2'd3
  } miter_state_t;

  localparam int DEF_W      = 1;
  localparam int DEF_DLY_G  = 0;
  localparam int DEF_DLY_R  = 0;
  localparam int DEF_WARMUP = 2;
  localparam int DEF_CNT_W  = 16;

  // Increment that sticks at vmax instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
    return (v >= vmax) ? vmax : v + 32'd1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eq_miter_mon_dly.sv
// miter_dly: N-stage shift register cleared to zero on reset; N=0 is a wire.
// Shifts every cycle so stream alignment never depends on monitor state.
module miter_dly #(
  parameter int W = 1,
  parameter int N = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (N == 0) begin : g_wire
      wire unused_ok = ^{clk, rst_n};
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] sr [N];

      // Shift the stream one stage per clock; flush to zero on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) sr[i] <= '0;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[N-1];
    end
  endgenerate

endmodule

// File: rtl/eq_miter_mon.sv
// eq_miter_mon: run-time miter comparing a golden and a revised output stream.
// Streams are aligned by miter_dly, start-up cycles are masked by a warm-up
// countdown, and the compare result is registered.
// Optional build macro: MITER_STOP_ON_FAIL_EN -- when defined the block freezes
// once it enters FAIL; otherwise it keeps comparing and counting in FAIL.
// Handshake: none; en/clr are level controls sampled on every rising edge.
module eq_miter_mon
  import eq_miter_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int DLY_G  = DEF_DLY_G,
  parameter int DLY_R  = DEF_DLY_R,
  parameter int WARMUP = DEF_WARMUP,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [W-1:0]     gold_x,
  input  logic [W-1:0]     rev_x,
  output logic             mismatch,
  output logic             fail,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] first_cyc,
  output logic [W-1:0]     first_diff
);

  // Warm-up also covers the longer delay line so reset zeros never get compared.
  localparam int LOAD = WARMUP + max_int(DLY_G, DLY_R);
  localparam int WC_W = (LOAD < 1) ? 1 : $clog2(LOAD + 1);
  localparam logic [WC_W-1:0] LOAD_V  = WC_W'(LOAD);
  localparam logic [31:0]     CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << CNT_W) - 32'd1);

  logic [W-1:0]     ag, ar, diff;
  logic             miscmp;
  logic [CNT_W-1:0] cyc_inc, mis_inc;

  miter_state_t     state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             mismatch_d, fail_d;
  logic [CNT_W-1:0] mis_cnt_d, cyc_cnt_d, first_cyc_d;
  logic [W-1:0]     first_diff_d;

  miter_dly #(.W(W), .N(DLY_G)) u_dly_g (.clk(clk), .rst_n(rst_n), .d(gold_x), .q(ag));
  miter_dly #(.W(W), .N(DLY_R)) u_dly_r (.clk(clk), .rst_n(rst_n), .d(rev_x),  .q(ar));

  assign diff    = ag ^ ar;
  assign miscmp  = |diff;
  assign cyc_inc = CNT_W'(sat_inc(32'(cyc_cnt), CNT_MAX));
  assign mis_inc = CNT_W'(sat_inc(32'(mis_cnt), CNT_MAX));
  assign state   = state_q;

  // Next-state and compare logic; clr overrides every state and discards a
  // same-cycle miscompare.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    mismatch_d   = 1'b0;
    fail_d       = fail;
    mis_cnt_d    = mis_cnt;
    cyc_cnt_d    = cyc_cnt;
    first_cyc_d  = first_cyc;
    first_diff_d = first_diff;
    if (clr) begin
      fail_d       = 1'b0;
      mis_cnt_d    = '0;
      cyc_cnt_d    = '0;
      first_cyc_d  = '0;
      first_diff_d = '0;
      wcnt_d       = LOAD_V;
      state_d      = en ? ST_WARMUP : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d = ST_WARMUP;
            wcnt_d  = LOAD_V;
          end
        end
        ST_WARMUP: begin
          if (!en)                state_d = ST_IDLE;
          else if (wcnt_q == '0)  state_d = ST_COMPARE;
          else                    wcnt_d  = wcnt_q - WC_W'(1);
        end
        ST_COMPARE: begin
          if (!en) begin
            state_d = ST_IDLE;
          end else begin
            cyc_cnt_d = cyc_inc;
            if (miscmp) begin
              mismatch_d   = 1'b1;
              mis_cnt_d    = mis_inc;
              fail_d       = 1'b1;
              first_cyc_d  = cyc_cnt;
              first_diff_d = diff;
              state_d      = ST_FAIL;
            end
          end
        end
        ST_FAIL: begin
`ifndef MITER_STOP_ON_FAIL_EN
          // Keep comparing after the first failure; first_* stay fixed.
          cyc_cnt_d = cyc_inc;
          if (miscmp) begin
            mismatch_d = 1'b1;
            mis_cnt_d  = mis_inc;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, warm-up counter and all reported statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      mismatch   <= 1'b0;
      fail       <= 1'b0;
      mis_cnt    <= '0;
      cyc_cnt    <= '0;
      first_cyc  <= '0;
      first_diff <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      mismatch   <= mismatch_d;
      fail       <= fail_d;
      mis_cnt    <= mis_cnt_d;
      cyc_cnt    <= cyc_cnt_d;
      first_cyc  <= first_cyc_d;
      first_diff <= first_diff_d;
    end
  end

endmodule

// File: tb/tb_eq_miter_mon.sv
// Bench for eq_miter_mon: two instances (wide/delayed and minimal 1-bit) share
// en/clr, driven with random streams and checked each cycle against a
// behavioural model, plus directed anchors from the test plan.
module tb_eq_miter_mon;

  localparam int P_IDLE = 0, P_WARM = 1, P_CMP = 2, P_FAIL = 3;

`ifdef MITER_STOP_ON_FAIL_EN
  localparam bit STOP_MODE = 1'b1;
`else
  localparam bit STOP_MODE = 1'b0;
`endif

  // Clock/reset and shared controls
  logic clk = 1'b0;
  logic rst_n, en, clr;
  always #5 clk = ~clk;

  // Instance A: W=4, DLY_G=2, DLY_R=1, WARMUP=2, CNT_W=4
  logic [3:0] gold_a, rev_a, fdiff_a, misc_a, cyc_a, fcyc_a;
  logic [1:0] st_a;
  logic       mm_a, fail_a;
  // Instance B: W=1, no delays, WARMUP=0, CNT_W=3
  logic       gold_b, rev_b, fdiff_b, mm_b, fail_b;
  logic [2:0] misc_b, cyc_b, fcyc_b;
  logic [1:0] st_b;

  eq_miter_mon #(.W(4), .DLY_G(2), .DLY_R(1), .WARMUP(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .gold_x(gold_a), .rev_x(rev_a),
    .mismatch(mm_a), .fail(fail_a), .state(st_a), .mis_cnt(misc_a), .cyc_cnt(cyc_a),
    .first_cyc(fcyc_a), .first_diff(fdiff_a));

  eq_miter_mon #(.W(1), .DLY_G(0), .DLY_R(0), .WARMUP(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .gold_x(gold_b), .rev_x(rev_b),
    .mismatch(mm_b), .fail(fail_b), .state(st_b), .mis_cnt(misc_b), .cyc_cnt(cyc_b),
    .first_cyc(fcyc_b), .first_diff(fdiff_b));

  // Reference model configuration and state, index 0 = A, 1 = B
  int         cfg_dg [2] = '{2, 0};
  int         cfg_dr [2] = '{1, 0};
  int         cfg_wu [2] = '{2, 0};
  int         cfg_max[2] = '{15, 7};
  logic [3:0] cfg_mask[2] = '{4'hF, 4'h1};

  int         m_phase[2], m_wc[2], m_mis[2], m_cyc[2], m_fcyc[2];
  logic [3:0] m_fdiff[2];
  bit         m_fail[2], m_mm[2];
  logic [3:0] hg[2][4], hr[2][4];   // past inputs, [0] = previous cycle

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] prev_gold_a;
  int a_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat1(input int v, input int vmax);
    return (v + 1 > vmax) ? vmax : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = P_IDLE; m_wc[i] = 0; m_mis[i] = 0; m_cyc[i] = 0; m_fcyc[i] = 0;
      m_fdiff[i] = '0; m_fail[i] = 0; m_mm[i] = 0;
      for (int k = 0; k < 4; k++) begin hg[i][k] = '0; hr[i][k] = '0; end
    end
  endtask

  // One rising edge of the model, using the inputs held across that edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] g, r, ag, ar, d;
      int load;
      g    = (i == 0) ? gold_a : {3'b000, gold_b};
      r    = (i == 0) ? rev_a  : {3'b000, rev_b};
      ag   = (cfg_dg[i] == 0) ? g : hg[i][cfg_dg[i]-1];
      ar   = (cfg_dr[i] == 0) ? r : hr[i][cfg_dr[i]-1];
      d    = (ag ^ ar) & cfg_mask[i];
      load = cfg_wu[i] + ((cfg_dg[i] > cfg_dr[i]) ? cfg_dg[i] : cfg_dr[i]);
      m_mm[i] = 0;
      if (clr) begin
        m_mis[i] = 0; m_cyc[i] = 0; m_fcyc[i] = 0; m_fdiff[i] = '0; m_fail[i] = 0;
        m_phase[i] = en ? P_WARM : P_IDLE;
        m_wc[i] = load;
      end else if (m_phase[i] == P_IDLE) begin
        if (en) begin m_phase[i] = P_WARM; m_wc[i] = load; end
      end else if (m_phase[i] == P_WARM) begin
        if (!en) m_phase[i] = P_IDLE;
        else if (m_wc[i] == 0) m_phase[i] = P_CMP;
        else m_wc[i]--;
      end else if (m_phase[i] == P_CMP) begin
        if (!en) m_phase[i] = P_IDLE;
        else begin
          if (d != 0) begin
            m_fcyc[i] = m_cyc[i]; m_fdiff[i] = d; m_fail[i] = 1; m_mm[i] = 1;
            m_mis[i] = sat1(m_mis[i], cfg_max[i]); m_phase[i] = P_FAIL;
          end
          m_cyc[i] = sat1(m_cyc[i], cfg_max[i]);
        end
      end else if (!STOP_MODE) begin
        if (d != 0) begin m_mm[i] = 1; m_mis[i] = sat1(m_mis[i], cfg_max[i]); end
        m_cyc[i] = sat1(m_cyc[i], cfg_max[i]);
      end
      for (int k = 3; k > 0; k--) begin hg[i][k] = hg[i][k-1]; hr[i][k] = hr[i][k-1]; end
      hg[i][0] = g; hr[i][0] = r;
    end
  endtask

  // Scoreboard: every output of both instances against the model.
  task automatic check_all();
    check("a.state", 32'(st_a), 32'(m_phase[0]));
    check("a.mismatch", 32'(mm_a), 32'(m_mm[0]));
    check("a.fail", 32'(fail_a), 32'(m_fail[0]));
    check("a.mis_cnt", 32'(misc_a), 32'(m_mis[0]));
    check("a.cyc_cnt", 32'(cyc_a), 32'(m_cyc[0]));
    check("a.first_cyc", 32'(fcyc_a), 32'(m_fcyc[0]));
    check("a.first_diff", 32'(fdiff_a), 32'(m_fdiff[0]));
    check("b.state", 32'(st_b), 32'(m_phase[1]));
    check("b.mismatch", 32'(mm_b), 32'(m_mm[1]));
    check("b.fail", 32'(fail_b), 32'(m_fail[1]));
    check("b.mis_cnt", 32'(misc_b), 32'(m_mis[1]));
    check("b.cyc_cnt", 32'(cyc_b), 32'(m_cyc[1]));
    check("b.first_cyc", 32'(fcyc_b), 32'(m_fcyc[1]));
    check("b.first_diff", 32'(fdiff_b), 32'(m_fdiff[1]));
  endtask

  // Driver: mode 0 = rev_a is gold_a one cycle late (aligned for A),
  // mode 1 = rev_a equals gold_a (misaligned for A). fa/fb are XOR faults.
  task automatic drive(input int mode, input logic [3:0] fa, input logic fb);
    logic [3:0] g;
    g      = 4'($urandom_range(0, 15));
    gold_a = g;
    rev_a  = ((mode == 0) ? prev_gold_a : g) ^ fa;
    prev_gold_a = g;
    gold_b = 1'($urandom_range(0, 1));
    rev_b  = gold_b ^ fb;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (mm_a) a_pulses++;
  endtask

  // Run aligned traffic until instance A is comparing, bounded.
  task automatic wait_a_compare(input string tag);
    int n;
    n = 0;
    while (m_phase[0] != P_CMP && n < 30) begin drive(0, 4'h0, 1'b0); cycle(); n++; end
    check(tag, 32'(m_phase[0] == P_CMP), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    gold_a = '0; rev_a = '0; gold_b = 1'b0; rev_b = 1'b0;
    prev_gold_a = '0; a_pulses = 0;
    model_reset();
    #2;
    check_all();
    #10 rst_n = 1'b1;

    // Equivalent streams: never fails, counters saturate
    en = 1'b1;
    repeat (60) begin drive(0, 4'h0, 1'b0); cycle(); end
    check("eq.a_fail", 32'(fail_a), 32'd0);
    check("eq.a_state", 32'(st_a), 32'd2);
    check("eq.a_cyc_sat", 32'(cyc_a), 32'd15);
    check("eq.b_cyc_sat", 32'(cyc_b), 32'd7);

    // Single fault on compared cycle 10 of A
    clr = 1'b1; drive(0, 4'h0, 1'b0); cycle(); clr = 1'b0;
    wait_a_compare("fault.reach_cmp");
    while (m_cyc[0] < 9) begin drive(0, 4'h0, 1'b0); cycle(); end
    a_pulses = 0;
    drive(0, 4'b0100, 1'b1); cycle();
    repeat (4) begin drive(0, 4'h0, 1'b0); cycle(); end
    check("fault.a_pulses", 32'(a_pulses), 32'd1);
    check("fault.a_fail", 32'(fail_a), 32'd1);
    check("fault.a_first_cyc", 32'(fcyc_a), 32'd10);
    check("fault.a_first_diff", 32'(fdiff_a), 32'h4);
    check("fault.a_state", 32'(st_a), 32'd3);
    check("fault.a_mis_cnt", 32'(misc_a), 32'd1);

    // clr coinciding with a miscompare on A is discarded
    clr = 1'b1; drive(0, 4'h0, 1'b0); cycle(); clr = 1'b0;
    wait_a_compare("clr.reach_cmp");
    drive(0, 4'h3, 1'b1); cycle();
    clr = 1'b1; drive(0, 4'h3, 1'b1); cycle(); clr = 1'b0;
    check("clr.a_fail", 32'(fail_a), 32'd0);
    check("clr.a_state", 32'(st_a), 32'd1);
    check("clr.a_mismatch", 32'(mm_a), 32'd0);
    check("clr.a_mis_cnt", 32'(misc_a), 32'd0);
    check("clr.b_fail", 32'(fail_b), 32'd0);

    // en dropped mid-compare: statistics held, state IDLE
    wait_a_compare("en.reach_cmp");
    en = 1'b0;
    repeat (3) begin drive(0, 4'h0, 1'b0); cycle(); end
    check("en.a_state", 32'(st_a), 32'd0);
    en = 1'b1;

    // Misaligned stream on A
    clr = 1'b1; drive(1, 4'h0, 1'b0); cycle(); clr = 1'b0;
    repeat (30) begin drive(1, 4'h0, 1'b0); cycle(); end

    // Permanent fault: saturation or freeze
    clr = 1'b1; drive(0, 4'hF, 1'b1); cycle(); clr = 1'b0;
    repeat (40) begin drive(0, 4'hF, 1'b1); cycle(); end
    check("sat.a_mis_cnt", 32'(misc_a), STOP_MODE ? 32'd1 : 32'd15);
    check("sat.b_mis_cnt", 32'(misc_b), STOP_MODE ? 32'd1 : 32'd7);
    check("sat.a_first_diff", 32'(fdiff_a), 32'hF);

    // Asynchronous reset between edges while comparing
    clr = 1'b1; drive(0, 4'h0, 1'b0); cycle(); clr = 1'b0;
    wait_a_compare("rst.reach_cmp");
    #2 rst_n = 1'b0;
    #1;
    model_reset(); prev_gold_a = '0;
    check_all();
    check("rst.a_state", 32'(st_a), 32'd0);
    #1 rst_n = 1'b1;

    // Random traffic with random en/clr/faults
    repeat (300) begin
      logic [3:0] fa;
      en  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 31) == 0);
      fa  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      drive(($urandom_range(0, 9) == 0) ? 1 : 0, fa, ($urandom_range(0, 19) == 0));
      cycle();
    end
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
